uart_alu_interface: RTL and testbench
=====================================

// Module: uart_alu_interface
// PURPOSE
//  Client-side controller that sits on the byte interface of the UART top (rd_uart/r_data/rx_empty,
//  wr_uart/w_data/tx_full) and drives it from the opposite end.
//  It collects three received bytes in order: operand A, operand B, opcode.
//  It executes one ALU operation and writes the 1-byte result back for transmission.
//  Runs as a command/response loop, one result byte per three command bytes.
// PARAMETERS
//  DBIT   8  data/operand/result width; must equal the UART data width
//  NB_OP  6  opcode width; opcode = r_data[NB_OP-1:0], upper bits of the opcode byte ignored
// PORTS
//  clk       in   1     system clock, all logic on rising edge
//  reset     in   1     synchronous, active-low reset (reset==0 clears block on next rising clk)
//  rx_empty  in   1     1 = no received byte pending; 0 = r_data valid
//  r_data    in   DBIT  received byte from UART rx flag buffer
//  tx_full   in   1     1 = UART tx buffer occupied, write not allowed
//  rd_uart   out  1     1-cycle pulse: consume current r_data (clears rx flag)
//  wr_uart   out  1     1-cycle pulse: load w_data into UART tx buffer
//  w_data    out  DBIT  result byte to transmit, registered, held until next result
// BEHAVIOUR
//  FSM states: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> SEND -> WAIT_A.
//  - WAIT_A/WAIT_B/WAIT_OP: if rx_empty==0, latch r_data into reg_a/reg_b/reg_op on that edge and advance.
//    rd_uart = (state is WAIT_x) && !rx_empty, combinational, so it is high exactly the one cycle the byte is taken.
//    If rx_empty==1, hold state with rd_uart=0.
//  - EXEC: one cycle; registers result into res_reg, always advances to SEND.
//  - SEND: if tx_full==0, wr_uart=1 (combinational) for this cycle, w_data<=res_reg on that edge, go to WAIT_A.
//    If tx_full==1, stay in SEND with wr_uart=0 indefinitely; no received bytes are consumed meanwhile.
//  - w_data is registered: updated on the edge where wr_uart is high, so the UART samples res_reg.
//    Implementation: w_data is driven from res_reg while in SEND, so the value is stable during the wr_uart cycle.
//  Latency: 3rd byte taken at edge n -> EXEC cycle n+1 -> earliest wr_uart in cycle n+2.
//  ALU ops (reg_op, NB_OP bits), unsigned DBIT-bit result, carries/overflow discarded:
//    6'h20 ADD  A+B mod 2^DBIT      6'h22 SUB  A-B mod 2^DBIT (two's complement wrap)
//    6'h24 AND  A&B                 6'h25 OR   A|B
//    6'h26 XOR  A^B                 6'h27 NOR  ~(A|B)
//    6'h03 SRA  A>>>B (A signed); if B>=DBIT, all bits = A[DBIT-1]
//    6'h02 SRL  A>>B; if B>=DBIT, result 0
//    any other opcode -> result 0, still transmitted (one response per command).
//  Reset (reset==0): state=WAIT_A, reg_a=reg_b=reg_op=res_reg=0, w_data=0; rd_uart=wr_uart=0 during reset.
//  Reset mid-command discards partial operands; the next three bytes form a fresh command.
//  Reset in SEND drops the pending result (no wr_uart).
//  rx_empty going low while in EXEC/SEND is ignored until return to WAIT_A (byte remains in UART buffer).
//  Never asserts rd_uart and wr_uart in the same cycle.
// TESTING
//  1. Bytes 0x05,0x03,0x20 -> exactly 3 rd_uart pulses, then one wr_uart with w_data=0x08.
//  2. Bytes 0x03,0x05,0x22 -> w_data=0xFE. Bytes 0xFF,0x02,0x20 -> 0x01 (wrap).
//  3. Bytes 0x80,0x02,0x03 (SRA) -> 0xE0. Bytes 0x80,0x09,0x03 -> 0xFF.
//     Bytes 0x80,0x09,0x02 (SRL) -> 0x00.
//  4. tx_full=1 for 10 cycles after EXEC -> wr_uart stays 0 and rd_uart stays 0 with rx_empty=0;
//     release -> single wr_uart pulse.
//  5. Send 0x11,0x22, pulse reset low 1 cycle, send 0x0C,0x0A,0x24 -> w_data=0x08, one wr_uart only.
//  6. Opcode byte 0x3F -> w_data=0x00. Opcode 0xE0 (upper bits set) behaves as 0x20.
//     rx_empty held 0 continuously -> rd_uart never high on two consecutive cycles beyond one per byte state.

Source files
------------

// File: rtl/uart_alu_if.sv
// Byte-level handshake between the UART top and the ALU command controller.
// The master modport belongs to the controller; the slave modport to the UART side.
interface uart_alu_if #(
    parameter int DBIT = 8
);
    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            tx_full;
    logic            rd_uart;
    logic            wr_uart;
    logic [DBIT-1:0] w_data;

    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, wr_uart, w_data
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, wr_uart, w_data
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Command/response controller: takes operand A, operand B and an opcode byte from the UART,
// runs one ALU operation and hands the 1-byte result back for transmission.
module uart_alu_interface #(
    parameter int DBIT  = 8,
    parameter int NB_OP = 6
) (
    input  logic         clk,
    input  logic         reset,
    uart_alu_if.master   bus
);

    localparam logic [2:0] WAIT_A  = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'('h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'('h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'('h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'('h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'('h26);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'('h27);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'('h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'('h02);

    localparam logic [DBIT:0] SHIFT_LIM = (DBIT+1)'(DBIT);

    logic [2:0]       state;
    logic [DBIT-1:0]  reg_a;
    logic [DBIT-1:0]  reg_b;
    logic [NB_OP-1:0] reg_op;
    logic [DBIT-1:0]  res_reg;
    logic [DBIT-1:0]  w_reg;
    logic [DBIT-1:0]  alu_res;
    logic             in_wait;
    logic             big_shift;

    assign in_wait   = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
    assign big_shift = ({1'b0, reg_b} >= SHIFT_LIM);

    always_comb begin
        alu_res = '0;
        case (reg_op)
            OP_ADD: alu_res = reg_a + reg_b;
            OP_SUB: alu_res = reg_a - reg_b;
            OP_AND: alu_res = reg_a & reg_b;
            OP_OR:  alu_res = reg_a | reg_b;
            OP_XOR: alu_res = reg_a ^ reg_b;
            OP_NOR: alu_res = ~(reg_a | reg_b);
            OP_SRA: alu_res = big_shift ? {DBIT{reg_a[DBIT-1]}}
                                        : DBIT'($signed(reg_a) >>> reg_b);
            OP_SRL: alu_res = big_shift ? '0 : (reg_a >> reg_b);
            default: alu_res = '0;
        endcase
    end

    // Strobes are gated by reset so nothing is consumed or sent while reset is held.
    assign bus.rd_uart = reset && in_wait && !bus.rx_empty;
    assign bus.wr_uart = reset && (state == SEND) && !bus.tx_full;
    // res_reg is presented directly during SEND so the UART samples the new result on the
    // write edge; w_reg keeps it visible afterwards until the next result replaces it.
    assign bus.w_data  = (state == SEND) ? res_reg : w_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= WAIT_A;
            reg_a   <= '0;
            reg_b   <= '0;
            reg_op  <= '0;
            res_reg <= '0;
            w_reg   <= '0;
        end else begin
            case (state)
                WAIT_A: if (!bus.rx_empty) begin
                    reg_a <= bus.r_data;
                    state <= WAIT_B;
                end
                WAIT_B: if (!bus.rx_empty) begin
                    reg_b <= bus.r_data;
                    state <= WAIT_OP;
                end
                WAIT_OP: if (!bus.rx_empty) begin
                    reg_op <= bus.r_data[NB_OP-1:0];
                    state  <= EXEC;
                end
                EXEC: begin
                    res_reg <= alu_res;
                    state   <= SEND;
                end
                SEND: if (!bus.tx_full) begin
                    w_reg <= res_reg;
                    state <= WAIT_A;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: feeds command bytes, checks strobes, latency and results.
module tb_uart_alu_interface;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    int   rd_cnt;
    int   wr_cnt;
    int   rd_run;
    int   max_run;
    logic both_seen;

    uart_alu_if #(.DBIT(8)) bus ();

    uart_alu_interface #(.DBIT(8), .NB_OP(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rd_cnt    = 0;
        wr_cnt    = 0;
        rd_run    = 0;
        max_run   = 0;
        both_seen = 1'b0;
    end

    // Strobe bookkeeping, sampled with the pre-edge values of the combinational outputs.
    always @(posedge clk) begin
        if (bus.rd_uart === 1'b1) rd_cnt <= rd_cnt + 1;
        if (bus.wr_uart === 1'b1) wr_cnt <= wr_cnt + 1;
        if (bus.rd_uart === 1'b1 && bus.wr_uart === 1'b1) both_seen <= 1'b1;
        rd_run  <= (bus.rd_uart === 1'b1) ? rd_run + 1 : 0;
        if (bus.rd_uart === 1'b1 && rd_run + 1 > max_run) max_run <= rd_run + 1;
    end

    // Present a byte and wait (bounded) for the DUT to take it; returns at the negedge after the take.
    task automatic give_byte(input logic [7:0] b, input string name);
        logic found;
        found = 1'b0;
        bus.r_data   = b;
        bus.rx_empty = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (bus.rd_uart === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_bad++;
            $display("FAIL %s rd_timeout byte=%02h: rd_uart=%b required 1", name, b, bus.rd_uart);
        end
        @(negedge clk);
    endtask

    // One complete command with exact latency: EXEC cycle has no strobe, next cycle writes.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input logic hold, input string name);
        give_byte(a, name);
        give_byte(b, name);
        give_byte(op, name);
        if (!hold) bus.rx_empty = 1'b1;
        #1;
        n_cmp++;
        if (bus.wr_uart !== 1'b0 || bus.rd_uart !== 1'b0) begin
            n_bad++;
            $display("FAIL %s exec_strobes: wr=%b rd=%b required 0 0", name, bus.wr_uart, bus.rd_uart);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.wr_uart !== 1'b1) begin
            n_bad++;
            $display("FAIL %s wr_latency: wr_uart=%b required 1", name, bus.wr_uart);
        end
        n_cmp++;
        if (bus.w_data !== exp) begin
            n_bad++;
            $display("FAIL %s w_data: got %02h required %02h", name, bus.w_data, exp);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.w_data !== exp || bus.wr_uart !== 1'b0) begin
            n_bad++;
            $display("FAIL %s w_hold: w_data=%02h wr=%b required %02h 0", name, bus.w_data, bus.wr_uart, exp);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.rx_empty = 1'b0;
        bus.r_data   = 8'h5A;
        bus.tx_full  = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++;
        if (bus.rd_uart !== 1'b0 || bus.wr_uart !== 1'b0 || bus.w_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: rd=%b wr=%b w_data=%02h required 0 0 00",
                     bus.rd_uart, bus.wr_uart, bus.w_data);
        end
        @(negedge clk);
        bus.rx_empty = 1'b1;
        reset = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.rd_uart !== 1'b0 || rd_cnt !== 0 || wr_cnt !== 0) begin
            n_bad++;
            $display("FAIL idle_after_reset: rd=%b rd_cnt=%0d wr_cnt=%0d required 0 0 0",
                     bus.rd_uart, rd_cnt, wr_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        int rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run_cmd(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, "add");
        @(negedge clk);
        n_cmp++;
        if (rd_cnt - rd0 !== 3 || wr_cnt - wr0 !== 1) begin
            n_bad++;
            $display("FAIL add_pulses: rd=%0d wr=%0d required 3 1", rd_cnt - rd0, wr_cnt - wr0);
        end
    endtask

    task automatic test_arith();
        run_cmd(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, "sub_wrap");
        run_cmd(8'hFF, 8'h02, 8'h20, 8'h01, 1'b0, "add_wrap");
        run_cmd(8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0, "and");
        run_cmd(8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b0, "or");
        run_cmd(8'h0F, 8'h33, 8'h26, 8'h3C, 1'b0, "xor");
        run_cmd(8'h0F, 8'h30, 8'h27, 8'hC0, 1'b0, "nor");
    endtask

    task automatic test_shift();
        run_cmd(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, "sra2");
        run_cmd(8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, "sra_big");
        run_cmd(8'h40, 8'h08, 8'h03, 8'h00, 1'b0, "sra_pos_big");
        run_cmd(8'h80, 8'h09, 8'h02, 8'h00, 1'b0, "srl_big");
        run_cmd(8'h80, 8'h02, 8'h02, 8'h20, 1'b0, "srl2");
    endtask

    task automatic test_tx_full();
        int wr0;
        bus.tx_full = 1'b1;
        give_byte(8'h0F, "txfull");
        give_byte(8'h33, "txfull");
        give_byte(8'h26, "txfull");
        bus.r_data   = 8'h55;
        bus.rx_empty = 1'b0;
        wr0 = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if (bus.wr_uart !== 1'b0 || bus.rd_uart !== 1'b0) begin
                n_bad++;
                $display("FAIL txfull_stall cyc=%0d: wr=%b rd=%b required 0 0", i, bus.wr_uart, bus.rd_uart);
            end
            @(negedge clk);
        end
        bus.tx_full = 1'b0;
        #1;
        n_cmp++;
        if (bus.wr_uart !== 1'b1 || bus.w_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL txfull_release: wr=%b w_data=%02h required 1 3C", bus.wr_uart, bus.w_data);
        end
        @(negedge clk);
        bus.rx_empty = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_cnt - wr0 !== 1) begin
            n_bad++;
            $display("FAIL txfull_single_wr: got %0d required 1", wr_cnt - wr0);
        end
    endtask

    task automatic test_reset_mid();
        int wr0;
        give_byte(8'h11, "rst_mid");
        give_byte(8'h22, "rst_mid");
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.rd_uart !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_rd: rd_uart=%b required 0", bus.rd_uart);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.rx_empty = 1'b1;
        wr0 = wr_cnt;
        run_cmd(8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0, "rst_mid_cmd");
        @(negedge clk);
        n_cmp++;
        if (wr_cnt - wr0 !== 1) begin
            n_bad++;
            $display("FAIL rst_mid_wr_count: got %0d required 1", wr_cnt - wr0);
        end
        // Reset while a result is waiting in SEND must drop it.
        bus.tx_full = 1'b1;
        give_byte(8'h10, "rst_send");
        give_byte(8'h20, "rst_send");
        give_byte(8'h20, "rst_send");
        bus.rx_empty = 1'b1;
        @(negedge clk);
        wr0 = wr_cnt;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.tx_full = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_cnt - wr0 !== 0 || bus.w_data !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_send_drop: wr=%0d w_data=%02h required 0 00", wr_cnt - wr0, bus.w_data);
        end
    endtask

    task automatic test_opcodes();
        run_cmd(8'h12, 8'h34, 8'h3F, 8'h00, 1'b0, "op_unknown");
        run_cmd(8'h10, 8'h20, 8'hE0, 8'h30, 1'b0, "op_upper_bits");
    endtask

    task automatic test_back_to_back();
        int rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run_cmd(8'h01, 8'h02, 8'h20, 8'h03, 1'b1, "b2b_1");
        run_cmd(8'hAA, 8'h0F, 8'h24, 8'h0A, 1'b1, "b2b_2");
        run_cmd(8'h07, 8'h09, 8'h22, 8'hFE, 1'b0, "b2b_3");
        @(negedge clk);
        n_cmp++;
        if (rd_cnt - rd0 !== 9 || wr_cnt - wr0 !== 3) begin
            n_bad++;
            $display("FAIL b2b_counts: rd=%0d wr=%0d required 9 3", rd_cnt - rd0, wr_cnt - wr0);
        end
        n_cmp++;
        if (max_run > 3 || both_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_strobes: max_rd_run=%0d rd_and_wr=%b required <=3 0", max_run, both_seen);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset        = 1'b0;
        bus.rx_empty = 1'b1;
        bus.r_data   = 8'h00;
        bus.tx_full  = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_arith();
        test_shift();
        test_tx_full();
        test_reset_mid();
        test_opcodes();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
